// File: rtl/if_ctrl.sv
// -----------------------------------------------------------------------------
// if_ctrl -- instruction-fetch control for a 5-stage MIPS-style pipeline.
//
// Sequences the fetch stage around a variable-latency instruction memory.
// It handles load-use stalls from ID and redirects (beq / j / jr) resolved in
// ID. It inserts IF/ID bubbles after a redirect and counts stall cycles.
//
// Parameters:
//   FLUSH_CYCLES    1..7  cycles if_id_flush is held per redirect, counting
//                         the redirect cycle itself.
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-high reset
//   imem_ack        in   instruction memory returns the requested word
//   load_use_hazard in   ID-stage load-use stall request
//   branch_taken    in   ID-stage beq resolved taken
//   jump            in   ID-stage j
//   jump_reg        in   ID-stage jr
//   pc_write        out  PC load enable
//   pc_src          out  next-PC select: 00 pc+4, 01 beq, 10 jr, 11 j
//   if_id_write     out  IF/ID load enable
//   if_id_flush     out  IF/ID clear (bubble insert)
//   imem_req        out  instruction fetch request
//   stall_cnt       out  saturating count of non-IDLE cycles with pc_write=0
//
// Handshake: imem_req is held high in every non-IDLE state. A cycle with
// imem_ack=1 completes the fetch. Only then may the PC advance or redirect.
// A redirect that arrives while the memory is still busy is parked in a
// one-entry pending register. That register is applied on the completing
// cycle.
// -----------------------------------------------------------------------------
module if_ctrl #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       imem_ack,
    input  logic       load_use_hazard,
    input  logic       branch_taken,
    input  logic       jump,
    input  logic       jump_reg,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       imem_req,
    output logic [7:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_M1 = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic       pend_valid_q, pend_valid_d;
    logic [1:0] pend_code_q, pend_code_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;

    // Redirect priority: jr > j > beq.
    logic       redir_valid;
    logic [1:0] redir_code;

    // Completion actions selected by the state decode below.
    logic       do_redir;
    logic       do_normal;
    logic [1:0] use_code;

    always_comb begin
        redir_valid = jump_reg | jump | branch_taken;
        if (jump_reg)      redir_code = 2'b10;
        else if (jump)     redir_code = 2'b11;
        else if (branch_taken) redir_code = 2'b01;
        else               redir_code = 2'b00;
    end

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        flush_cnt_d  = flush_cnt_q;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        imem_req     = 1'b0;
        do_redir     = 1'b0;
        do_normal    = 1'b0;
        use_code     = 2'b00;

        case (state_q)
            S_IDLE: begin
                if_id_flush = 1'b1;
                state_d     = S_FETCH;
            end

            S_FETCH: begin
                imem_req = 1'b1;
                // A hazard freezes everything. Redirects are dropped because ID
                // re-presents them once the stall clears.
                if (!load_use_hazard) begin
                    if (imem_ack) begin
                        if (redir_valid) begin
                            do_redir = 1'b1;
                            use_code = redir_code;
                        end else begin
                            do_normal = 1'b1;
                        end
                    end else begin
                        state_d = S_WAIT;
                        if (redir_valid) begin
                            pend_valid_d = 1'b1;
                            pend_code_d  = redir_code;
                        end
                    end
                end
            end

            S_WAIT: begin
                imem_req = 1'b1;
                if (!load_use_hazard) begin
                    if (imem_ack) begin
                        pend_valid_d = 1'b0;
                        // The parked redirect wins. Otherwise a redirect
                        // arriving on the completing cycle is still honoured.
                        if (pend_valid_q) begin
                            do_redir = 1'b1;
                            use_code = pend_code_q;
                        end else if (redir_valid) begin
                            do_redir = 1'b1;
                            use_code = redir_code;
                        end else begin
                            do_normal = 1'b1;
                        end
                    end else if (!pend_valid_q && redir_valid) begin
                        pend_valid_d = 1'b1;
                        pend_code_d  = redir_code;
                    end
                end
            end

            S_FLUSH: begin
                imem_req    = 1'b1;
                if_id_flush = 1'b1;
                pc_write    = imem_ack;
                if (imem_ack) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q <= 3'd1) begin
                        state_d = S_FETCH;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_normal) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            state_d     = S_FETCH;
        end

        if (do_redir) begin
            pc_write    = 1'b1;
            pc_src      = use_code;
            if_id_flush = 1'b1;
            flush_cnt_d = FLUSH_M1;
            state_d     = (FLUSH_CYCLES > 1) ? S_FLUSH : S_FETCH;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != S_IDLE && !pc_write && stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pend_valid_q <= 1'b0;
            pend_code_q  <= 2'b00;
            flush_cnt_q  <= 3'd0;
            stall_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            flush_cnt_q  <= flush_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_ctrl.sv
module tb_if_ctrl;

    logic       clk;
    logic       reset;
    logic       imem_ack;
    logic       load_use_hazard;
    logic       branch_taken;
    logic       jump;
    logic       jump_reg;

    logic       pc_write, if_id_write, if_id_flush, imem_req;
    logic [1:0] pc_src;
    logic [7:0] stall_cnt;

    logic       pc_write_1, if_id_write_1, if_id_flush_1, imem_req_1;
    logic [1:0] pc_src_1;
    logic [7:0] stall_cnt_1;

    int checks;
    int failures;

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_ctrl #(.FLUSH_CYCLES(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_ack        (imem_ack),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .jump            (jump),
        .jump_reg        (jump_reg),
        .pc_write        (pc_write),
        .pc_src          (pc_src),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .imem_req        (imem_req),
        .stall_cnt       (stall_cnt)
    );

    if_ctrl dut1 (
        .clk             (clk),
        .reset           (reset),
        .imem_ack        (imem_ack),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .jump            (jump),
        .jump_reg        (jump_reg),
        .pc_write        (pc_write_1),
        .pc_src          (pc_src_1),
        .if_id_write     (if_id_write_1),
        .if_id_flush     (if_id_flush_1),
        .imem_req        (imem_req_1),
        .stall_cnt       (stall_cnt_1)
    );

    // Checkers
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks {pc_write, pc_src, if_id_write, if_id_flush, imem_req} of the
    // FLUSH_CYCLES=3 instance as one packed vector.
    task automatic chk_outs(input string tag, input logic pw, input logic [1:0] src,
                            input logic iw, input logic fl, input logic rq);
        chk(tag, {3'b000, pc_write, pc_src, if_id_write, if_id_flush, imem_req},
                 {3'b000, pw, src, iw, fl, rq});
    endtask

    task automatic chk_outs1(input string tag, input logic pw, input logic [1:0] src,
                             input logic iw, input logic fl, input logic rq);
        chk(tag, {3'b000, pc_write_1, pc_src_1, if_id_write_1, if_id_flush_1, imem_req_1},
                 {3'b000, pw, src, iw, fl, rq});
    endtask

    // Driver tasks: inputs change just after the falling edge, outputs are
    // sampled 1 time unit later, well away from the rising edge.
    task automatic apply(input logic ack, input logic haz, input logic br,
                         input logic j, input logic jr);
        @(negedge clk);
        imem_ack        = ack;
        load_use_hazard = haz;
        branch_taken    = br;
        jump            = j;
        jump_reg        = jr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b0; load_use_hazard = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b1;
        imem_ack = 1'b0; load_use_hazard = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_outs("reset_outs", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("reset_stall", stall_cnt, 8'd0);

        // Reset release with ack held: one IDLE cycle, then straight-line fetch.
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b1;
        #1;
        chk_outs("idle_cycle", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_outs($sformatf("seq_fetch_%0d", i), 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        end
        chk("seq_stall", stall_cnt, 8'd0);

        // jr + j together: jr wins. FLUSH_CYCLES=3 holds flush for 3 cycles;
        // the default instance flushes once and goes back to straight fetch.
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_outs("redir_jr", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
        chk_outs1("redir_jr_fc1", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs("flush_2", 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        chk_outs1("fc1_back_fetch", 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_outs("flush_3_ignore_jr", 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs("flush_done", 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        chk("flush_stall", stall_cnt, 8'd0);

        // beq while memory busy for 3 cycles; a later j must not replace it.
        do_reset();
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_outs("busy_1", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("busy_1_stall", stall_cnt, 8'd0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_outs("busy_2", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_outs("busy_3", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_stall", stall_cnt, 8'd3);
        chk_outs("pending_beq", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);

        // Load-use hazard blocks a simultaneous taken branch completely.
        do_reset();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs("pre_hazard", 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_outs("hazard", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs("post_hazard", 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        chk("hazard_stall", stall_cnt, 8'd1);

        // Reset in WAIT with a pending jump: immediate IDLE, jump discarded.
        do_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_outs("async_reset", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("async_reset_stall", stall_cnt, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_outs($sformatf("no_stale_jump_%0d", i), 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        end

        // Long memory stall: counter climbs then saturates at 255.
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 101) chk("stall_100", stall_cnt, 8'd100);
            if (k == 256) chk("stall_255", stall_cnt, 8'd255);
        end
        chk("stall_sat", stall_cnt, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
